// File: rtl/tm_pkg.sv
// Definitions shared by the TM classifier stages: default sizes, the argmax
// state encoding and the most-negative class sum.
package tm_pkg;

  localparam int TM_NUM_CLASSES = 10;
  localparam int TM_INT_SIZE    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } argmax_state_e;

  localparam logic [TM_INT_SIZE-1:0] SUM_MIN = {1'b1, {(TM_INT_SIZE-1){1'b0}}};

endpackage

// File: rtl/tm_argmax_cmp.sv
// One step of the running argmax: folds candidate (s, idx) into (best, best_idx, second).
// A candidate equal to best never takes the win, so the lowest index wins ties.
module tm_argmax_cmp #(
  parameter int INT_SIZE = 32,
  parameter int IDX_W    = 4
) (
  input  logic signed [INT_SIZE-1:0] best_i,
  input  logic        [IDX_W-1:0]    best_idx_i,
  input  logic signed [INT_SIZE-1:0] second_i,
  input  logic signed [INT_SIZE-1:0] s_i,
  input  logic        [IDX_W-1:0]    idx_i,
  output logic signed [INT_SIZE-1:0] best_o,
  output logic        [IDX_W-1:0]    best_idx_o,
  output logic signed [INT_SIZE-1:0] second_o
);

  always_comb begin
    best_o     = best_i;
    best_idx_o = best_idx_i;
    second_o   = second_i;
    if (s_i > best_i) begin
      second_o   = best_i;
      best_o     = s_i;
      best_idx_o = idx_i;
    end else if (s_i > second_i) begin
      second_o = s_i;
    end
  end

endmodule

// File: rtl/tm_class_argmax.sv
// Serial argmax over the classifier's class sums: one class per cycle, then the
// winner, its margin over the runner-up and a tie flag are held on valid/ready.
module tm_class_argmax
  import tm_pkg::*;
#(
  parameter int NUM_CLASSES = TM_NUM_CLASSES,
  parameter int INT_SIZE    = TM_INT_SIZE,
  parameter int IDX_W       = 4
) (
  input  logic                            clk,
  input  logic                            rst_flag,
  input  logic [NUM_CLASSES*INT_SIZE-1:0] class_sums,
  input  logic                            full_done,
  input  logic                            pred_ready,
  output logic                            pred_valid,
  output logic [IDX_W-1:0]                pred_class,
  output logic [INT_SIZE-1:0]             pred_sum,
  output logic [INT_SIZE:0]               pred_margin,
  output logic                            pred_tie,
  output logic                            busy,
  output logic                            overrun
);

  localparam logic [INT_SIZE-1:0] MIN_S    = {1'b1, {(INT_SIZE-1){1'b0}}};
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  argmax_state_e state_q, state_d;
  logic                       full_done_q;
  logic                       rise;
  logic                       capture;
  logic signed [INT_SIZE-1:0] sums_in [NUM_CLASSES];
  logic signed [INT_SIZE-1:0] sums_q  [NUM_CLASSES];

  logic signed [INT_SIZE-1:0] best_q, best_d, second_q, second_d;
  logic        [IDX_W-1:0]    best_idx_q, best_idx_d, idx_q, idx_d;
  logic                       valid_q, valid_d, tie_q, tie_d, overrun_q, overrun_d;
  logic        [IDX_W-1:0]    class_q, class_d;
  logic        [INT_SIZE-1:0] sum_q, sum_d;
  logic        [INT_SIZE:0]   margin_q, margin_d;

  logic signed [INT_SIZE-1:0] cmp_best, cmp_second;
  logic        [IDX_W-1:0]    cmp_best_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_unpack
      assign sums_in[gi] = class_sums[gi*INT_SIZE +: INT_SIZE];
    end
  endgenerate

  assign rise = full_done & ~full_done_q;

  tm_argmax_cmp #(
    .INT_SIZE (INT_SIZE),
    .IDX_W    (IDX_W)
  ) u_cmp (
    .best_i     (best_q),
    .best_idx_i (best_idx_q),
    .second_i   (second_q),
    .s_i        (sums_q[idx_q]),
    .idx_i      (idx_q),
    .best_o     (cmp_best),
    .best_idx_o (cmp_best_idx),
    .second_o   (cmp_second)
  );

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    second_d   = second_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    class_d    = class_q;
    sum_d      = sum_q;
    margin_d   = margin_q;
    tie_d      = tie_q;
    // Any rise outside IDLE (including the acceptance cycle) is lost.
    overrun_d  = overrun_q | (rise & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (rise) begin
          capture    = 1'b1;
          best_d     = sums_in[0];
          best_idx_d = '0;
          second_d   = MIN_S;
          idx_d      = IDX_W'(1);
          state_d    = SCAN;
        end
      end
      SCAN: begin
        best_d     = cmp_best;
        best_idx_d = cmp_best_idx;
        second_d   = cmp_second;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d  = HOLD;
          valid_d  = 1'b1;
          class_d  = cmp_best_idx;
          sum_d    = cmp_best;
          // One extra bit keeps best - second non-negative even for MAX - MIN.
          margin_d = {cmp_best[INT_SIZE-1], cmp_best} - {cmp_second[INT_SIZE-1], cmp_second};
          tie_d    = (cmp_best == cmp_second);
        end
      end
      HOLD: begin
        if (valid_q && pred_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_flag) begin
      state_q     <= IDLE;
      full_done_q <= 1'b0;
      best_q      <= '0;
      best_idx_q  <= '0;
      second_q    <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      class_q     <= '0;
      sum_q       <= '0;
      margin_q    <= '0;
      tie_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_done_q <= full_done;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      second_q    <= second_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      class_q     <= class_d;
      sum_q       <= sum_d;
      margin_q    <= margin_d;
      tie_q       <= tie_d;
      overrun_q   <= overrun_d;
    end
  end

  // Shadow copy lets class_sums move on while the scan runs.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        sums_q[k] <= sums_in[k];
      end
    end
  end

  assign pred_valid  = valid_q;
  assign pred_class  = class_q;
  assign pred_sum    = sum_q;
  assign pred_margin = margin_q;
  assign pred_tie    = tie_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_tm_class_argmax.sv
// Scoreboard bench for tm_class_argmax: a reference argmax model queues the
// expected result at each full_done rise; results are popped on handshake.
module tb_tm_class_argmax;

  localparam int NC = 10;
  localparam int IS = 32;
  localparam int IW = 4;
  localparam logic signed [IS-1:0] SMIN = 32'sh8000_0000;
  localparam logic signed [IS-1:0] SMAX = 32'sh7FFF_FFFF;

  typedef struct packed {
    logic [IW-1:0] cls;
    logic [IS-1:0] sum;
    logic [IS:0]   margin;
    logic          tie;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_flag;
  logic [NC*IS-1:0]  class_sums;
  logic              full_done;
  logic              pred_ready;
  logic              pred_valid;
  logic [IW-1:0]     pred_class;
  logic [IS-1:0]     pred_sum;
  logic [IS:0]       pred_margin;
  logic              pred_tie;
  logic              busy;
  logic              overrun;

  logic signed [IS-1:0] sums_tb [NC];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_cnt = 0;
  int   txn_no   = 0;

  always #5 clk = ~clk;

  always_comb begin
    class_sums = '0;
    for (int k = 0; k < NC; k++) class_sums[k*IS +: IS] = sums_tb[k];
  end

  tm_class_argmax #(.NUM_CLASSES(NC), .INT_SIZE(IS), .IDX_W(IW)) dut (
    .clk         (clk),
    .rst_flag    (rst_flag),
    .class_sums  (class_sums),
    .full_done   (full_done),
    .pred_ready  (pred_ready),
    .pred_valid  (pred_valid),
    .pred_class  (pred_class),
    .pred_sum    (pred_sum),
    .pred_margin (pred_margin),
    .pred_tie    (pred_tie),
    .busy        (busy),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  // Reference: first maximum by index, runner-up is the largest of the rest.
  function automatic exp_t model(input logic signed [IS-1:0] a [NC]);
    exp_t e;
    int bi = 0;
    logic signed [IS-1:0] sec = SMIN;
    for (int k = 1; k < NC; k++) if (a[k] > a[bi]) bi = k;
    for (int k = 0; k < NC; k++) if (k != bi && a[k] > sec) sec = a[k];
    e.cls    = IW'(bi);
    e.sum    = a[bi];
    e.margin = $signed({a[bi][IS-1], a[bi]}) - $signed({sec[IS-1], sec});
    e.tie    = (a[bi] == sec);
    return e;
  endfunction

  task automatic raise_done(input bit push);
    if (push) sb_q.push_back(model(sums_tb));
    full_done = 1'b1;
    edge_cnt  = 0;
    tick();
    full_done = 1'b0;
  endtask

  // Waits for pred_valid, checks latency and data against the scoreboard head.
  task automatic wait_result(input string tag);
    exp_t e;
    while (!pred_valid && edge_cnt < 40) tick();
    check({tag, "_latency"}, 64'(edge_cnt), 64'(NC));
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_valid"},  64'(pred_valid), 64'd1);
      check({tag, "_busy"},   64'(busy), 64'd1);
      check({tag, "_class"},  64'(pred_class), 64'(e.cls));
      check({tag, "_sum"},    64'(pred_sum), 64'(e.sum));
      check({tag, "_margin"}, 64'(pred_margin), 64'(e.margin));
      check({tag, "_tie"},    64'(pred_tie), 64'(e.tie));
      txn_no++;
      $display("txn %0d %s: class=%0d sum=%0d margin=%0h tie=%0b", txn_no, tag,
               pred_class, $signed(pred_sum), pred_margin, pred_tie);
    end
  endtask

  task automatic accept(input string tag);
    logic [IW-1:0] cls_keep;
    cls_keep   = pred_class;
    pred_ready = 1'b1;
    tick();
    check({tag, "_acc_valid"}, 64'(pred_valid), 64'd0);
    check({tag, "_acc_busy"},  64'(busy), 64'd0);
    check({tag, "_acc_keep"},  64'(pred_class), 64'(cls_keep));
  endtask

  initial begin
    bit saw_valid;
    logic [IS:0] m_keep;
    rst_flag   = 1'b1;
    full_done  = 1'b0;
    pred_ready = 1'b1;
    for (int k = 0; k < NC; k++) sums_tb[k] = '0;
    tick();
    tick();
    check("rst_valid",   64'(pred_valid), 64'd0);
    check("rst_class",   64'(pred_class), 64'd0);
    check("rst_sum",     64'(pred_sum), 64'd0);
    check("rst_margin",  64'(pred_margin), 64'd0);
    check("rst_tie",     64'(pred_tie), 64'd0);
    check("rst_busy",    64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst_flag = 1'b0;
    tick();

    // Tie between classes 2 and 5, lowest index wins.
    sums_tb = '{5, -3, 12, 0, 7, 12, -100, 4, 1, 2};
    raise_done(1'b1);
    wait_result("tie12");
    accept("tie12");
    check("tie12_class_abs", 64'(pred_class), 64'd2);
    tick();

    // All most-negative.
    for (int k = 0; k < NC; k++) sums_tb[k] = SMIN;
    raise_done(1'b1);
    wait_result("allmin");
    accept("allmin");
    tick();

    // Descending negatives with a 5-cycle stall.
    for (int k = 0; k < NC; k++) sums_tb[k] = -(10 * (k + 1));
    pred_ready = 1'b0;
    raise_done(1'b1);
    wait_result("stall");
    m_keep = pred_margin;
    check("stall_margin_abs", 64'(pred_margin), 64'd10);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stall_hold_valid",  64'(pred_valid), 64'd1);
      check("stall_hold_margin", 64'(pred_margin), 64'(m_keep));
      check("stall_hold_class",  64'(pred_class), 64'd0);
    end
    accept("stall");
    tick();

    // Extremes: MAX vs zeros, then MAX vs MIN.
    for (int k = 0; k < NC; k++) sums_tb[k] = '0;
    sums_tb[0] = SMIN;
    sums_tb[9] = SMAX;
    raise_done(1'b1);
    wait_result("max0");
    check("max0_margin_abs", 64'(pred_margin), 64'h7FFF_FFFF);
    accept("max0");
    for (int k = 1; k < 9; k++) sums_tb[k] = SMIN;
    raise_done(1'b1);
    wait_result("maxmin");
    check("maxmin_margin_abs", 64'(pred_margin), 64'h0_FFFF_FFFF);
    accept("maxmin");
    tick();

    // Second rise mid-scan with changed sums: dropped, overrun set.
    sums_tb = '{1, 2, 3, 40, 5, 6, 7, 8, 9, 10};
    raise_done(1'b1);
    for (int k = 0; k < NC; k++) sums_tb[k] = 100 - k;
    tick();
    tick();
    full_done = 1'b1;
    tick();
    full_done = 1'b0;
    check("ovr_set", 64'(overrun), 64'd1);
    wait_result("ovr");
    accept("ovr");
    tick();
    check("ovr_sticky", 64'(overrun), 64'd1);

    // Reset mid-scan aborts; the next rise completes.
    raise_done(1'b0);
    tick();
    tick();
    tick();
    rst_flag = 1'b1;
    tick();
    rst_flag = 1'b0;
    check("abort_valid",   64'(pred_valid), 64'd0);
    check("abort_busy",    64'(busy), 64'd0);
    check("abort_overrun", 64'(overrun), 64'd0);
    check("abort_class",   64'(pred_class), 64'd0);
    check("abort_margin",  64'(pred_margin), 64'd0);
    saw_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (pred_valid) saw_valid = 1'b1;
    end
    check("abort_no_valid", 64'(saw_valid), 64'd0);
    sums_tb = '{-7, 3, 3, 2, -1, 0, 9, 8, 9, 1};
    raise_done(1'b1);
    wait_result("post_rst");
    accept("post_rst");
    check("post_rst_overrun", 64'(overrun), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
